// File: rtl/eeprom_pkg.sv
// Shared types and constants for the serial EEPROM responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eeprom_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_CMD,
        ST_READ,
        ST_WDATA,
        ST_WAIT_CE,
        ST_BUSY
    } state_t;

    // What a ce fall in WAIT_CE will commit
    typedef enum logic [1:0] {
        CK_WORD,
        CK_ALL,
        CK_EWEN,
        CK_EWDS
    } commit_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b11;
    localparam logic [1:0] OP_EXT   = 2'b00;

    localparam logic [1:0] EXT_EWEN = 2'b11;
    localparam logic [1:0] EXT_EWDS = 2'b00;
    localparam logic [1:0] EXT_ERAL = 2'b10;
    localparam logic [1:0] EXT_WRAL = 2'b01;

    localparam int          WORD_W = 16;
    localparam logic [15:0] ERASED = 16'hFFFF;

endpackage

// File: rtl/eeprom_serial_responder_sync.sv
// Two-flop synchronizer with rising/falling edge detect on the synchronized level.
// Latency: sync 2 clocks after din; rise/fall valid in the same cycle as the new sync level.
// Backpressure: none, free-running.
module sync_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/eeprom_serial_responder.sv
// Microwire-style serial EEPROM responder (READ/WRITE/ERASE/EWEN/EWDS/ERAL/WRAL); EEPROM_BUSY_EN adds a program-busy phase.
// Latency: eeprom_do updates 3 clocks after a raw eeprom_clock rise; commits 3 clocks after a raw ce fall.
// Backpressure: none; with EEPROM_BUSY_EN, eeprom_do low (while ce high) signals not-ready and commands are ignored.
module eeprom_serial_responder #(
    parameter int ADDR_W      = 6,
    parameter int BUSY_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic eeprom_ce,
    input  logic eeprom_clock,
    input  logic eeprom_di,
    output logic eeprom_do,
    output logic busy,
    output logic write_enabled
);
    import eeprom_pkg::*;

    localparam int DEPTH    = 1 << ADDR_W;
    localparam int CMD_BITS = ADDR_W + 2;
    localparam int CNT_MAX  = (CMD_BITS > WORD_W) ? CMD_BITS : WORD_W;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int BUSY_W   = $clog2(BUSY_CYCLES + 1);

    logic ce_s, ce_fall, ce_rise_unused;
    logic clk_rise, clk_fall_unused;
    logic di_s, di_rise_unused, di_fall_unused;

    sync_edge_detect u_ce  (.clock(clock), .reset(reset), .din(eeprom_ce),
                            .sync(ce_s), .rise(ce_rise_unused), .fall(ce_fall));
    sync_edge_detect u_clk (.clock(clock), .reset(reset), .din(eeprom_clock),
                            .sync(), .rise(clk_rise), .fall(clk_fall_unused));
    sync_edge_detect u_di  (.clock(clock), .reset(reset), .din(eeprom_di),
                            .sync(di_s), .rise(di_rise_unused), .fall(di_fall_unused));

    state_t              state;
    commit_t             kind;
    logic [15:0]         mem [DEPTH];
    logic [ADDR_W-1:0]   addr;
    logic [CMD_BITS-2:0] cmd_sr;
    logic [15:0]         data_sr;
    logic [CNT_W-1:0]    bit_cnt;
    logic [3:0]          bit_idx;
    logic [BUSY_W-1:0]   busy_cnt;

    logic [CMD_BITS-1:0] cmd_word;
    logic [1:0]          cmd_op;
    logic [1:0]          cmd_ext;
    logic [ADDR_W-1:0]   cmd_addr;

    assign cmd_word = {cmd_sr, di_s};
    assign cmd_op   = cmd_word[CMD_BITS-1 -: 2];
    assign cmd_ext  = cmd_word[ADDR_W-1 -: 2];
    assign cmd_addr = cmd_word[ADDR_W-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            kind          <= CK_WORD;
            eeprom_do     <= 1'b1;
            busy          <= 1'b0;
            write_enabled <= 1'b0;
            addr          <= '0;
            cmd_sr        <= '0;
            data_sr       <= '0;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            busy_cnt      <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= ERASED;
        end else if (state == ST_BUSY) begin
            eeprom_do <= ~ce_s;
            if (busy_cnt == '0) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                eeprom_do <= 1'b1;
            end else begin
                busy_cnt <= busy_cnt - 1'b1;
            end
        end else if (!ce_s) begin
            // ce low always ends the transaction; it also wins over a same-cycle serial edge
            state     <= ST_IDLE;
            eeprom_do <= 1'b1;
            if (state == ST_WAIT_CE && ce_fall) begin
                unique case (kind)
                    CK_EWEN: write_enabled <= 1'b1;
                    CK_EWDS: write_enabled <= 1'b0;
                    CK_WORD, CK_ALL: begin
                        if (write_enabled) begin
                            if (kind == CK_ALL) begin
                                for (int i = 0; i < DEPTH; i++) mem[i] <= data_sr;
                            end else begin
                                mem[addr] <= data_sr;
                            end
                            busy_cnt <= BUSY_W'(BUSY_CYCLES - 1);
`ifdef EEPROM_BUSY_EN
                            state <= ST_BUSY;
                            busy  <= 1'b1;
`endif
                        end
                    end
                endcase
            end
        end else begin
            unique case (state)
                ST_IDLE: state <= ST_START;
                ST_START: begin
                    if (clk_rise && di_s) begin
                        state   <= ST_CMD;
                        bit_cnt <= '0;
                    end
                end
                ST_CMD: begin
                    if (clk_rise) begin
                        cmd_sr  <= cmd_word[CMD_BITS-2:0];
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(CMD_BITS - 1)) begin
                            addr    <= cmd_addr;
                            bit_cnt <= '0;
                            unique case (cmd_op)
                                OP_READ: begin
                                    state     <= ST_READ;
                                    eeprom_do <= 1'b0;
                                    bit_idx   <= 4'd15;
                                end
                                OP_WRITE: begin
                                    state <= ST_WDATA;
                                    kind  <= CK_WORD;
                                end
                                OP_ERASE: begin
                                    state   <= ST_WAIT_CE;
                                    kind    <= CK_WORD;
                                    data_sr <= ERASED;
                                end
                                OP_EXT: begin
                                    unique case (cmd_ext)
                                        EXT_EWEN: begin
                                            state <= ST_WAIT_CE;
                                            kind  <= CK_EWEN;
                                        end
                                        EXT_EWDS: begin
                                            state <= ST_WAIT_CE;
                                            kind  <= CK_EWDS;
                                        end
                                        EXT_ERAL: begin
                                            state   <= ST_WAIT_CE;
                                            kind    <= CK_ALL;
                                            data_sr <= ERASED;
                                        end
                                        EXT_WRAL: begin
                                            state <= ST_WDATA;
                                            kind  <= CK_ALL;
                                        end
                                    endcase
                                end
                            endcase
                        end
                    end
                end
                ST_READ: begin
                    // bit_idx wraps 0 -> 15 as the address steps to the next word
                    if (clk_rise) begin
                        eeprom_do <= mem[addr][bit_idx];
                        bit_idx   <= bit_idx - 1'b1;
                        if (bit_idx == 4'd0) addr <= addr + 1'b1;
                    end
                end
                ST_WDATA: begin
                    if (clk_rise) begin
                        data_sr <= {data_sr[14:0], di_s};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(WORD_W - 1)) state <= ST_WAIT_CE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_serial_responder.sv
// Directed bench for eeprom_serial_responder with a bit-level read scoreboard.
module tb_eeprom_serial_responder;
    import eeprom_pkg::*;

    localparam int AW   = 6;
    localparam int BUSY = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic eeprom_ce = 1'b0;
    logic eeprom_clock = 1'b0;
    logic eeprom_di = 1'b0;
    logic eeprom_do, busy, write_enabled;

    eeprom_serial_responder #(.ADDR_W(AW), .BUSY_CYCLES(BUSY)) dut (
        .clock(clock), .reset(reset), .eeprom_ce(eeprom_ce), .eeprom_clock(eeprom_clock),
        .eeprom_di(eeprom_di), .eeprom_do(eeprom_do), .busy(busy), .write_enabled(write_enabled)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int errors = 0;
    logic exp_q[$];
    logic [15:0] mdl [1 << AW];
    logic mdl_we;
    int busy_hi;

    always @(negedge clock) if (busy) busy_hi++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic obs);
        logic e;
        if (exp_q.size() == 0) e = 1'bx;
        else e = exp_q.pop_front();
        check(tag, {31'd0, obs}, {31'd0, e});
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic sbit(input logic b, output logic d);
        eeprom_di = b;
        wait_clk(2);
        eeprom_clock = 1'b1;
        wait_clk(5);
        d = eeprom_do;
        eeprom_clock = 1'b0;
        wait_clk(3);
    endtask

    task automatic ce_on();
        eeprom_ce = 1'b1;
        wait_clk(4);
    endtask

    task automatic ce_off();
        eeprom_ce = 1'b0;
        wait_clk(6);
        for (int g = 0; g < 4 * BUSY && busy; g++) wait_clk(1);
    endtask

    // one ignored leading 0, start bit, opcode, address
    task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a, output logic d);
        sbit(1'b0, d);
        sbit(1'b1, d);
        sbit(op[1], d);
        sbit(op[0], d);
        for (int i = AW - 1; i >= 0; i--) sbit(a[i], d);
    endtask

    task automatic ext_cmd(input logic [1:0] code);
        logic d;
        ce_on();
        send_cmd(OP_EXT, {code, {(AW-2){1'b0}}}, d);
        ce_off();
        if (code == EXT_EWEN) mdl_we = 1'b1;
        if (code == EXT_EWDS) mdl_we = 1'b0;
        if (code == EXT_ERAL && mdl_we) for (int i = 0; i < (1 << AW); i++) mdl[i] = ERASED;
    endtask

    task automatic write_bits(input logic [1:0] op, input logic [AW-1:0] a,
                              input logic [15:0] data, input int nbits);
        logic d;
        ce_on();
        send_cmd(op, a, d);
        for (int i = 0; i < nbits; i++) sbit(data[15-i], d);
        ce_off();
        if (nbits == 16 && mdl_we) begin
            if (op == OP_EXT) for (int i = 0; i < (1 << AW); i++) mdl[i] = data;
            else mdl[a] = data;
        end
    endtask

    task automatic erase_word(input logic [AW-1:0] a);
        logic d;
        ce_on();
        send_cmd(OP_ERASE, a, d);
        ce_off();
        if (mdl_we) mdl[a] = ERASED;
    endtask

    task automatic read_words(input string tag, input logic [AW-1:0] a, input int n);
        logic d;
        logic [AW-1:0] p;
        exp_q.push_back(1'b0);
        p = a;
        for (int w = 0; w < n; w++) begin
            for (int b = 15; b >= 0; b--) exp_q.push_back(mdl[p][b]);
            p = p + 1'b1;
        end
        ce_on();
        send_cmd(OP_READ, a, d);
        pop_check({tag, "_dummy"}, d);
        for (int i = 0; i < 16 * n; i++) begin
            sbit(1'b0, d);
            pop_check(tag, d);
        end
        ce_off();
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mdl[i] = ERASED;
        mdl_we = 1'b0;
        wait_clk(4);
        check("rst_do", {31'd0, eeprom_do}, 1);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_we", {31'd0, write_enabled}, 0);
        reset = 1'b1;
        wait_clk(3);

        read_words("rd5_6", 6'd5, 2);

        ext_cmd(EXT_EWEN);
        check("ewen_we", {31'd0, write_enabled}, 1);
        write_bits(OP_WRITE, 6'd3, 16'hA55A, 16);
        read_words("rd3_a55a", 6'd3, 1);

        ext_cmd(EXT_EWDS);
        check("ewds_we", {31'd0, write_enabled}, 0);
        busy_hi = 0;
        write_bits(OP_WRITE, 6'd3, 16'h1234, 16);
        check("wp_busy_cycles", busy_hi, 0);
        read_words("rd3_protected", 6'd3, 1);

        ext_cmd(EXT_EWEN);
        write_bits(OP_WRITE, 6'd7, 16'h5A5A, 9);
        read_words("rd7_partial", 6'd7, 1);
        read_words("rd3_after_partial", 6'd3, 1);

        write_bits(OP_WRITE, 6'd8, 16'h1357, 16);
        erase_word(6'd3);
        read_words("rd3_8_erase", 6'd3, 6);

        write_bits(OP_EXT, {EXT_WRAL, 4'd0}, 16'hC3C3, 16);
        read_words("rd_wral", 6'd40, 2);
        write_bits(OP_WRITE, 6'd63, 16'hBEEF, 16);
        write_bits(OP_WRITE, 6'd0, 16'h0F0F, 16);
        read_words("rd_wrap", 6'd63, 2);

`ifdef EEPROM_BUSY_EN
        begin
            logic d;
            int g;
            ce_on();
            send_cmd(OP_EXT, {EXT_ERAL, 4'd0}, d);
            busy_hi = 0;
            eeprom_ce = 1'b0;
            for (g = 0; g < 20 && !busy; g++) wait_clk(1);
            check("eral_busy_rose", {31'd0, busy}, 1);
            eeprom_ce = 1'b1;
            wait_clk(6);
            check("busy_do_low", {31'd0, eeprom_do}, 0);
            for (g = 0; g < 4 * BUSY && busy; g++) wait_clk(1);
            wait_clk(2);
            check("busy_len", busy_hi, BUSY);
            check("ready_do_high", {31'd0, eeprom_do}, 1);
            eeprom_ce = 1'b0;
            wait_clk(6);
            for (int i = 0; i < (1 << AW); i++) mdl[i] = ERASED;
        end
`else
        busy_hi = 0;
        ext_cmd(EXT_ERAL);
        check("eral_busy_cycles", busy_hi, 0);
        check("eral_do_high", {31'd0, eeprom_do}, 1);
`endif
        read_words("rd_all_erased", 6'd0, 1 << AW);

        write_bits(OP_WRITE, 6'd12, 16'h6789, 16);
        read_words("rd12", 6'd12, 1);
        reset = 1'b0;
        wait_clk(3);
        reset = 1'b1;
        wait_clk(3);
        for (int i = 0; i < (1 << AW); i++) mdl[i] = ERASED;
        mdl_we = 1'b0;
        check("rst2_we", {31'd0, write_enabled}, 0);
        read_words("rd12_after_reset", 6'd12, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
